// File: rtl/path_walker.sv
// Sprite walker along a parametrised monotone polyline with hold, win and rate-limited stepping.
// Optional macro STEP_REPEAT_EN: held buttons auto-repeat every STEP_DIV cycles; otherwise one step per press.
module path_walker #(
  parameter int X_W      = 7,
  parameter int Y_W      = 6,
  parameter int NSEG     = 7,
  parameter logic [(NSEG+1)*X_W-1:0] PATH_X = {7'd92, 7'd71, 7'd71, 7'd47, 7'd47, 7'd23, 7'd23, 7'd2},
  parameter logic [(NSEG+1)*Y_W-1:0] PATH_Y = {6'd61, 6'd61, 6'd45, 6'd45, 6'd29, 6'd29, 6'd13, 6'd13},
  parameter int STEP_DIV = 1,
  parameter int CD_W     = 3
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [CD_W-1:0]            cd_cnt,
  input  logic                       btnR,
  input  logic                       btnD,
  input  logic                       btnL,
  input  logic                       btnU,
  output logic [X_W-1:0]             x,
  output logic [Y_W-1:0]             y,
  output logic [$clog2(NSEG+1)-1:0]  seg,
  output logic                       step,
  output logic                       win
);

  localparam int SW = $clog2(NSEG+1);
  localparam logic [SW-1:0] LAST_SEG = SW'(NSEG-1);

  typedef enum logic [1:0] {HOLD, WALK, WIN} state_t;

  state_t         state_reg, state_next;
  logic [X_W-1:0] x_reg, x_next;
  logic [Y_W-1:0] y_reg, y_next;
  logic [SW-1:0]  seg_reg, seg_next;
  logic           step_reg, step_next;
  logic           win_reg, win_next;

  logic [X_W-1:0] pt_x [NSEG+1];
  logic [Y_W-1:0] pt_y [NSEG+1];

  genvar gi;
  generate
    for (gi = 0; gi <= NSEG; gi++) begin : g_pt
      assign pt_x[gi] = PATH_X[gi*X_W +: X_W];
      assign pt_y[gi] = PATH_Y[gi*Y_W +: Y_W];
    end
  endgenerate

  logic r_req, d_req, l_req, u_req;
  logic timer_zero;

`ifdef STEP_REPEAT_EN
  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  logic [TW-1:0] timer_reg, timer_next;

  assign {r_req, d_req, l_req, u_req} = {btnR, btnD, btnL, btnU};
  assign timer_zero = (timer_reg == '0);
`else
  logic [3:0] btn_prev_reg;
  logic       unused_step_div;

  // Only rising edges count as requests, so a held button moves exactly once.
  assign {r_req, d_req, l_req, u_req} = {btnR, btnD, btnL, btnU} & ~btn_prev_reg;
  assign timer_zero      = 1'b1;
  assign unused_step_div = (STEP_DIV > 0);

  always_ff @(posedge clk) begin
    if (clr) btn_prev_reg <= '0;
    else     btn_prev_reg <= {btnR, btnD, btnL, btnU};
  end
`endif

  logic [SW-1:0] seg_p1, seg_m1;
  logic at_start, at_goal, horiz, bwd_horiz;
  logic fwd_req, bwd_req, bwd_blocked, active;

  assign seg_p1   = seg_reg + SW'(1);
  assign seg_m1   = seg_reg - SW'(1);
  assign at_start = (x_reg == pt_x[seg_reg]) && (y_reg == pt_y[seg_reg]);
  assign at_goal  = (x_reg == pt_x[NSEG]) && (y_reg == pt_y[NSEG]);
  assign horiz    = ~seg_reg[0];
  // Sitting on a corner, backing up travels along the previous segment's axis.
  assign bwd_horiz   = (at_start && seg_reg != '0) ? seg_reg[0] : ~seg_reg[0];
  assign fwd_req     = horiz ? r_req : d_req;
  assign bwd_req     = bwd_horiz ? l_req : u_req;
  assign bwd_blocked = at_start && (seg_reg == '0);
  assign active      = (fwd_req ^ bwd_req) && !(bwd_req && bwd_blocked);

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    seg_next   = seg_reg;
    step_next  = 1'b0;
    win_next   = win_reg;
`ifdef STEP_REPEAT_EN
    timer_next = '0;
`endif
    case (state_reg)
      HOLD: begin
        x_next   = pt_x[0];
        y_next   = pt_y[0];
        seg_next = '0;
        if (cd_cnt == '0) state_next = WALK;
      end
      WALK: begin
        if (at_goal) begin
          state_next = WIN;
          win_next   = 1'b1;
        end else if (cd_cnt != '0) begin
          state_next = HOLD;
          x_next     = pt_x[0];
          y_next     = pt_y[0];
          seg_next   = '0;
        end else if (active) begin
`ifdef STEP_REPEAT_EN
          timer_next = timer_zero ? TW'(STEP_DIV-1) : timer_reg - TW'(1);
`endif
          if (timer_zero) begin
            step_next = 1'b1;
            if (fwd_req) begin
              if (horiz) x_next = x_reg + X_W'(1);
              else       y_next = y_reg + Y_W'(1);
              if (x_next == pt_x[seg_p1] && y_next == pt_y[seg_p1] && seg_reg != LAST_SEG)
                seg_next = seg_p1;
            end else begin
              if (bwd_horiz) x_next = x_reg - X_W'(1);
              else           y_next = y_reg - Y_W'(1);
              if (at_start) seg_next = seg_m1;
            end
          end
        end
      end
      WIN: begin
        win_next = 1'b1;
      end
      default: state_next = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= HOLD;
      x_reg     <= PATH_X[X_W-1:0];
      y_reg     <= PATH_Y[Y_W-1:0];
      seg_reg   <= '0;
      step_reg  <= 1'b0;
      win_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      seg_reg   <= seg_next;
      step_reg  <= step_next;
      win_reg   <= win_next;
    end
  end

`ifdef STEP_REPEAT_EN
  always_ff @(posedge clk) begin
    if (clr) timer_reg <= '0;
    else     timer_reg <= timer_next;
  end
`endif

  assign x    = x_reg;
  assign y    = y_reg;
  assign seg  = seg_reg;
  assign step = step_reg;
  assign win  = win_reg;

endmodule
